// File: rtl/mul16_shift_add.sv
`default_nettype none
// ============================================================================
// Module      : Adder_16 / mul16_shift_add
// Description : Sequential 16x16 unsigned shift-add multiplier built around
//               a single 16-bit adder, with valid/ready handshakes on the
//               operand side and the result side.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Adder_16 ports
//   x, y      in  16  addends
//   cin       in   1  carry in
//   sum       out 16  x + y + cin (low 16 bits)
//   cout      out  1  carry out
// mul16_shift_add ports
//   clk       in   1  clock, rising edge
//   rst_n     in   1  synchronous active-low reset
//   in_valid  in   1  operands a/b valid
//   in_ready  out  1  operands can be accepted (IDLE only)
//   a         in  16  multiplicand
//   b         in  16  multiplier
//   out_valid out  1  product valid, held until taken
//   out_ready in   1  consumer accepts product
//   product   out 32  a*b, unsigned
//   busy      out  1  operation in progress or result pending
// ============================================================================

module Adder_16 (
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);
  assign {cout, sum} = {1'b0, x} + {1'b0, y} + {16'h0000, cin};
endmodule

module mul16_shift_add #(
  parameter int EARLY_EXIT = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] product,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state, state_next;
  logic [15:0] a_reg, a_next;
  logic [31:0] p_reg, p_next;
  logic [4:0]  cnt, cnt_next;
  logic [31:0] product_next;
  logic        out_valid_next;

  // Adder datapath: upper half of P plus the multiplicand gated by the
  // current multiplier bit. y is always driven, never left floating.
  logic [15:0] add_y;
  logic [15:0] add_sum;
  logic        add_cout;

  assign add_y = p_reg[0] ? a_reg : 16'h0000;

  Adder_16 u_adder (
    .x    (p_reg[31:16]),
    .y    (add_y),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Early termination: when every not-yet-processed multiplier bit
  // (P[15-cnt:0]) is zero, the remaining iterations would only shift, so the
  // final alignment is done in one go.
  logic        exit_now;
  logic [31:0] exit_p;

  generate
    if (EARLY_EXIT != 0) begin : g_early_exit
      logic [15:0] unproc_mask;
      logic [4:0]  shamt;
      assign unproc_mask = 16'hFFFF >> cnt;
      assign shamt       = 5'd16 - cnt;
      assign exit_now    = ((p_reg[15:0] & unproc_mask) == 16'h0000);
      assign exit_p      = p_reg >> shamt;
    end else begin : g_no_early_exit
      assign exit_now = 1'b0;
      assign exit_p   = p_reg;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      a_reg     <= 16'h0000;
      p_reg     <= 32'h0000_0000;
      cnt       <= 5'd0;
      product   <= 32'h0000_0000;
      out_valid <= 1'b0;
    end else begin
      state     <= state_next;
      a_reg     <= a_next;
      p_reg     <= p_next;
      cnt       <= cnt_next;
      product   <= product_next;
      out_valid <= out_valid_next;
    end
  end

  always_comb begin
    state_next     = state;
    a_next         = a_reg;
    p_next         = p_reg;
    cnt_next       = cnt;
    product_next   = product;
    out_valid_next = out_valid;

    case (state)
      S_IDLE: begin
        if (in_valid) begin
          a_next     = a;
          p_next     = {16'h0000, b};
          cnt_next   = 5'd0;
          state_next = S_CALC;
        end
      end

      S_CALC: begin
        if (exit_now) begin
          p_next         = exit_p;
          product_next   = exit_p;
          out_valid_next = 1'b1;
          state_next     = S_DONE;
        end else begin
          // {cout,sum} is at most 17 bits and lands above the 15 remaining
          // multiplier bits, so the shifted P never loses a carry.
          p_next   = {add_cout, add_sum, p_reg[15:1]};
          cnt_next = cnt + 5'd1;
          if (cnt == 5'd15) begin
            product_next   = {add_cout, add_sum, p_reg[15:1]};
            out_valid_next = 1'b1;
            state_next     = S_DONE;
          end
        end
      end

      S_DONE: begin
        if (out_ready) begin
          out_valid_next = 1'b0;
          state_next     = S_IDLE;
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign in_ready = (state == S_IDLE);
  assign busy     = (state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mul16_shift_add.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul16_shift_add
// Description : Self-checking bench for mul16_shift_add. One instance with
//               EARLY_EXIT=0 and one with EARLY_EXIT=1 share clock and reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mul16_shift_add;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        in_valid0 = 1'b0, in_ready0, out_valid0, out_ready0 = 1'b1, busy0;
  logic [15:0] a0 = '0, b0 = '0;
  logic [31:0] product0;

  logic        in_valid1 = 1'b0, in_ready1, out_valid1, out_ready1 = 1'b1, busy1;
  logic [15:0] a1 = '0, b1 = '0;
  logic [31:0] product1;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  mul16_shift_add #(.EARLY_EXIT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0),
    .a(a0), .b(b0), .out_valid(out_valid0), .out_ready(out_ready0),
    .product(product0), .busy(busy0)
  );

  mul16_shift_add #(.EARLY_EXIT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .out_valid(out_valid1), .out_ready(out_ready1),
    .product(product1), .busy(busy1)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] exp_p;
    int          exp_lat;
  } vec_t;

  vec_t v0[6];
  vec_t v1[6];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic get_ir(input int sel);
    return (sel != 0) ? in_ready1 : in_ready0;
  endfunction

  function automatic logic get_ov(input int sel);
    return (sel != 0) ? out_valid1 : out_valid0;
  endfunction

  function automatic logic [31:0] get_p(input int sel);
    return (sel != 0) ? product1 : product0;
  endfunction

  function automatic logic get_busy(input int sel);
    return (sel != 0) ? busy1 : busy0;
  endfunction

  task automatic drive(input int sel, input logic v, input logic [15:0] av, input logic [15:0] bv);
    if (sel != 0) begin
      in_valid1 = v; a1 = av; b1 = bv;
    end else begin
      in_valid0 = v; a0 = av; b0 = bv;
    end
  endtask

  // Steps until out_valid rises or a budget of 40 cycles expires.
  task automatic wait_valid(input int sel, output int lat);
    lat = 0;
    while (!get_ov(sel) && lat < 40) begin
      step();
      lat++;
    end
  endtask

  // One complete operation with out_ready held high. Latency counts edges
  // after the accepting edge up to the one that raises out_valid.
  task automatic run_op(input int sel, input string name, input logic [15:0] av,
                        input logic [15:0] bv, input logic [31:0] exp_p, input int exp_lat);
    int lat;
    check({name, " in_ready before accept"}, {31'd0, get_ir(sel)}, 32'd1);
    drive(sel, 1'b1, av, bv);
    step();
    drive(sel, 1'b0, 16'hDEAD, 16'hBEEF);
    check({name, " busy after accept"}, {31'd0, get_busy(sel)}, 32'd1);
    wait_valid(sel, lat);
    check({name, " latency"}, lat, exp_lat);
    check({name, " product"}, get_p(sel), exp_p);
    step();
    check({name, " out_valid cleared"}, {31'd0, get_ov(sel)}, 32'd0);
    check({name, " in_ready after take"}, {31'd0, get_ir(sel)}, 32'd1);
  endtask

  initial begin
    int lat;
    logic [15:0] ra, rb;

    // No early exit: always 16 CALC edges.
    v0[0] = '{16'd3,    16'd5,    32'h0000_000F, 16};
    v0[1] = '{16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 16};
    v0[2] = '{16'h0000, 16'h1234, 32'h0000_0000, 16};
    v0[3] = '{16'h8000, 16'h0002, 32'h0001_0000, 16};
    v0[4] = '{16'h1234, 16'h0000, 32'h0000_0000, 16};
    v0[5] = '{16'h00FF, 16'h0100, 32'h0000_FF00, 16};
    // Early exit: highest set bit h of b gives latency h+2 (max 16), b==0 gives 1.
    v1[0] = '{16'h00AB, 16'h0003, 32'h0000_0201, 3};
    v1[1] = '{16'h5555, 16'h0000, 32'h0000_0000, 1};
    v1[2] = '{16'h1234, 16'h00FF, 32'h0012_21CC, 9};
    v1[3] = '{16'hFFFF, 16'h8000, 32'h7FFF_8000, 16};
    v1[4] = '{16'h0007, 16'h0001, 32'h0000_0007, 2};
    v1[5] = '{16'hFFFF, 16'h4000, 32'h3FFF_C000, 16};

    // Reset state
    step(); step();
    check("reset in_ready",  {31'd0, in_ready0},  32'd1);
    check("reset out_valid", {31'd0, out_valid0}, 32'd0);
    check("reset busy",      {31'd0, busy0},      32'd0);
    check("reset product",   product0,            32'd0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 6; i++)
      run_op(0, $sformatf("ee0 vec%0d", i), v0[i].a, v0[i].b, v0[i].exp_p, v0[i].exp_lat);
    for (int i = 0; i < 6; i++)
      run_op(1, $sformatf("ee1 vec%0d", i), v1[i].a, v1[i].b, v1[i].exp_p, v1[i].exp_lat);

    // Result held in DONE while out_ready is low; new operands ignored.
    out_ready0 = 1'b0;
    drive(0, 1'b1, 16'h1234, 16'h00FF);
    step();
    drive(0, 1'b1, 16'h0002, 16'h0003);
    wait_valid(0, lat);
    check("hold latency", lat, 16);
    for (int i = 0; i < 5; i++) begin
      step();
      check("hold product",   product0,            32'h0012_21CC);
      check("hold out_valid", {31'd0, out_valid0}, 32'd1);
      check("hold in_ready",  {31'd0, in_ready0},  32'd0);
    end
    out_ready0 = 1'b1;
    step();
    check("take out_valid", {31'd0, out_valid0}, 32'd0);
    check("take in_ready",  {31'd0, in_ready0},  32'd1);
    check("take product kept", product0, 32'h0012_21CC);
    step();
    drive(0, 1'b0, 16'h0000, 16'h0000);
    check("accept after take busy", {31'd0, busy0}, 32'd1);
    wait_valid(0, lat);
    check("accept after take product", product0, 32'd6);
    step();

    // Reset in the middle of CALC discards the operation.
    drive(0, 1'b1, 16'hFFFF, 16'hFFFF);
    step();
    drive(0, 1'b0, 16'h0000, 16'h0000);
    for (int i = 0; i < 8; i++) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("midreset in_ready",  {31'd0, in_ready0},  32'd1);
    check("midreset out_valid", {31'd0, out_valid0}, 32'd0);
    check("midreset product",   product0,            32'd0);
    lat = 0;
    while (lat < 20) begin
      step();
      lat++;
      if (out_valid0) begin
        check("midreset spurious out_valid", {31'd0, out_valid0}, 32'd0);
        break;
      end
    end
    run_op(0, "after reset 7*9", 16'd7, 16'd9, 32'd63, 16);

    // Back-to-back: in_valid held high, operands garbage while busy.
    in_valid0 = 1'b1;
    for (int i = 0; i < 200; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      lat = 0;
      while (!in_ready0 && lat < 40) begin
        a0 = 16'($urandom); b0 = 16'($urandom);
        step();
        lat++;
      end
      check("b2b in_ready", {31'd0, in_ready0}, 32'd1);
      a0 = ra; b0 = rb;
      step();
      check("b2b accepted", {31'd0, busy0}, 32'd1);
      lat = 0;
      while (!out_valid0 && lat < 40) begin
        a0 = 16'($urandom); b0 = 16'($urandom);
        step();
        lat++;
      end
      check($sformatf("b2b product %0d", i), product0, {16'h0000, ra} * {16'h0000, rb});
      step();
    end
    in_valid0 = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire
